outmem_reader: RTL and testbench

OUTMEM_READER -- requirements
Module: outmem_reader

---
 rtl/outmem_reader.sv | 157 +++++++++++++++
 tb/tb_outmem_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outmem_reader.sv
// outmem_reader: streams a T x M result tile out of the 64-bit output SRAM.
// Each SRAM word holds four DW-bit lanes (lane 0 in the top bits). Row r uses
// word 2r for cols 0..3 and word 2r+1 for cols 4..7. Each word goes through
// RD (one-cycle chip enable), CAP (latch read data) and EMIT (one element per
// accepted handshake).
module outmem_reader #(
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          START,
  input  logic [11:0]   MNT,
  output logic          EN_O,
  output logic          RW_O,
  output logic [3:0]    ADDR_O,
  input  logic [63:0]   RDATA_O,
  output logic          O_VALID,
  input  logic          O_READY,
  output logic [DW-1:0] O_DATA,
  output logic [2:0]    O_ROW,
  output logic [2:0]    O_COL,
  output logic          O_LAST,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_EMIT, S_DONE} state_t;

  state_t      r_state;
  logic [63:0] r_buf;
  logic [3:0]  r_m, r_t;
  logic [2:0]  r_row;
  logic        r_hi;
  logic [1:0]  r_lane;

  logic [3:0]  w_m, w_t;
  logic        w_bad;
  logic [1:0]  w_lmax, w_lane_nx;
  logic        w_row_last, w_more_hi, w_last_word;
  logic        w_unused_n;

  assign RW_O = 1'b0;

  // N plays no part in the readout
  assign w_unused_n = ^MNT[7:4];

  assign w_m   = MNT[11:8];
  assign w_t   = MNT[3:0];
  assign w_bad = (w_m == 4'd0) || (w_m > 4'd8) || (w_t == 4'd0) || (w_t > 4'd8);

  // Last lane index of the current word: upper word carries cols 4..M-1
  assign w_lmax      = r_hi ? 2'(r_m - 4'd5) : ((r_m >= 4'd4) ? 2'd3 : 2'(r_m - 4'd1));
  assign w_lane_nx   = r_lane + 2'd1;
  assign w_row_last  = ({1'b0, r_row} == (r_t - 4'd1));
  assign w_more_hi   = (r_m > 4'd4) && !r_hi;
  assign w_last_word = w_row_last && !w_more_hi;

  function automatic logic [DW-1:0] lane_sel(input logic [63:0] w, input logic [1:0] l);
    case (l)
      2'd0:    return w[4*DW-1 -: DW];
      2'd1:    return w[3*DW-1 -: DW];
      2'd2:    return w[2*DW-1 -: DW];
      default: return w[DW-1:0];
    endcase
  endfunction

  // Readout FSM; every output is registered
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_m     <= '0;
      r_t     <= '0;
      r_row   <= '0;
      r_hi    <= 1'b0;
      r_lane  <= '0;
      EN_O    <= 1'b0;
      ADDR_O  <= '0;
      O_VALID <= 1'b0;
      O_DATA  <= '0;
      O_ROW   <= '0;
      O_COL   <= '0;
      O_LAST  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_m    <= w_m;
            r_t    <= w_t;
            r_row  <= '0;
            r_hi   <= 1'b0;
            r_lane <= '0;
            if (w_bad) begin
              ERR     <= 1'b1;
              DONE    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              ERR     <= 1'b0;
              EN_O    <= 1'b1;
              ADDR_O  <= '0;
              BUSY    <= 1'b1;
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          EN_O    <= 1'b0;
          r_state <= S_CAP;
        end
        S_CAP: begin
          r_buf   <= RDATA_O;
          r_lane  <= '0;
          O_VALID <= 1'b1;
          O_DATA  <= lane_sel(RDATA_O, 2'd0);
          O_ROW   <= r_row;
          O_COL   <= {r_hi, 2'b00};
          O_LAST  <= w_row_last && ({1'b0, r_hi, 2'b00} == (r_m - 4'd1));
          r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (O_READY) begin
            if (r_lane == w_lmax) begin
              O_VALID <= 1'b0;
              O_LAST  <= 1'b0;
              if (w_last_word) begin
                BUSY    <= 1'b0;
                DONE    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                EN_O    <= 1'b1;
                ADDR_O  <= w_more_hi ? {r_row, 1'b1} : {r_row + 3'd1, 1'b0};
                r_hi    <= w_more_hi;
                if (!w_more_hi) r_row <= r_row + 3'd1;
                r_state <= S_RD;
              end
            end else begin
              r_lane <= w_lane_nx;
              O_DATA <= lane_sel(r_buf, w_lane_nx);
              O_COL  <= {r_hi, w_lane_nx};
              O_LAST <= w_row_last && ({1'b0, r_hi, w_lane_nx} == (r_m - 4'd1));
            end
          end
        end
        S_DONE: begin
          DONE    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_outmem_reader.sv
// tb_outmem_reader: directed bench with an SRAM model and element/address
// scoreboards for outmem_reader.
module tb_outmem_reader;
  logic        CLK = 1'b0;
  logic        RSTN, START, O_READY;
  logic [11:0] MNT;
  logic [63:0] RDATA_O = '0;
  logic        EN_O, RW_O, O_VALID, O_LAST, BUSY, DONE, ERR;
  logic [3:0]  ADDR_O;
  logic [15:0] O_DATA;
  logic [2:0]  O_ROW, O_COL;

  outmem_reader #(.DW(16)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .MNT(MNT),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .RDATA_O(RDATA_O),
    .O_VALID(O_VALID), .O_READY(O_READY), .O_DATA(O_DATA),
    .O_ROW(O_ROW), .O_COL(O_COL), .O_LAST(O_LAST),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // SRAM model: data for the enabled address appears the next cycle
  logic [63:0] mem [16];
  always @(posedge CLK) if (EN_O) RDATA_O <= mem[ADDR_O];

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  r;
    logic [2:0]  c;
    logic        l;
  } elem_t;

  elem_t      exp_q[$];
  logic [3:0] addr_q[$];
  int         n_chk = 0, n_fail = 0, en_cnt = 0, done_cnt = 0;
  bit         rnd = 0;
  elem_t      prev, cur, e;
  bit         prev_stall = 0;
  logic [3:0] ea;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_run(input int m, input int t);
    for (int r = 0; r < t; r++) begin
      addr_q.push_back(4'(2*r));
      if (m > 4) addr_q.push_back(4'(2*r + 1));
      for (int c = 0; c < m; c++) begin
        elem_t x;
        int a, ln;
        a   = 2*r + (c >= 4 ? 1 : 0);
        ln  = c % 4;
        x.d = mem[a][63-16*ln -: 16];
        x.r = 3'(r);
        x.c = 3'(c);
        x.l = (r == t-1) && (c == m-1);
        exp_q.push_back(x);
      end
    end
  endtask

  // Monitor: scoreboard pops, address order, stall stability, DONE pulses
  always @(negedge CLK) begin
    if (RSTN) begin
      cur = {O_DATA, O_ROW, O_COL, O_LAST};
      if (prev_stall) begin
        chk("stall_valid", O_VALID, 1'b1);
        chk("stall_hold", cur, prev);
      end
      prev_stall = O_VALID && !O_READY;
      prev = cur;
      if (EN_O) begin
        en_cnt++;
        chk("addr_expected", addr_q.size() > 0, 1'b1);
        if (addr_q.size() > 0) begin
          ea = addr_q.pop_front();
          chk("addr", ADDR_O, ea);
        end
      end
      if (O_VALID && O_READY) begin
        chk("elem_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("elem", cur, e);
        end
      end
      if (DONE) done_cnt++;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_pulse(input logic [11:0] v);
    MNT = v;
    START = 1'b1;
    cyc();
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      if (rnd) O_READY = 1'($urandom_range(0, 1));
      cyc();
      if (DONE) begin
        got = 1;
        break;
      end
    end
    chk("done_timeout", got, 1'b1);
    rnd = 0;
    O_READY = 1'b1;
  endtask

  task automatic chk_zero();
    chk("rst_en", EN_O, 1'b0);
    chk("rst_addr", ADDR_O, 4'h0);
    chk("rst_valid", O_VALID, 1'b0);
    chk("rst_data", O_DATA, 16'h0);
    chk("rst_row", O_ROW, 3'h0);
    chk("rst_col", O_COL, 3'h0);
    chk("rst_last", O_LAST, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rw", RW_O, 1'b0);
  endtask

  task automatic fill_mem();
    for (int a = 0; a < 16; a++) mem[a] = {$urandom, $urandom};
  endtask

  task automatic run_done_checks(input string tag, input int en_exp, input int done_exp);
    chk({tag, "_elems_left"}, exp_q.size(), 0);
    chk({tag, "_addrs_left"}, addr_q.size(), 0);
    chk({tag, "_en_count"}, en_cnt, en_exp);
    chk({tag, "_done_count"}, done_cnt, done_exp);
  endtask

  initial begin
    RSTN = 1'b0; START = 1'b0; O_READY = 1'b1; MNT = '0;
    fill_mem();
    #12;
    chk_zero();
    cyc(); cyc();
    RSTN = 1'b1;
    cyc();

    // 7 x 3 tile with a free-running sink, including first-element latency
    en_cnt = 0; done_cnt = 0;
    push_run(7, 3);
    start_pulse(12'h763);
    chk("t1_rd_en", EN_O, 1'b1);
    chk("t1_rd_busy", BUSY, 1'b1);
    chk("t1_rd_valid", O_VALID, 1'b0);
    cyc();
    chk("t1_cap_en", EN_O, 1'b0);
    chk("t1_cap_valid", O_VALID, 1'b0);
    cyc();
    chk("t1_emit_valid", O_VALID, 1'b1);
    wait_done(200);
    chk("t1_err", ERR, 1'b0);
    cyc();
    chk("t1_done_pulse", DONE, 1'b0);
    chk("t1_idle_busy", BUSY, 1'b0);
    run_done_checks("t1", 6, 1);

    // Invalid shapes: M=9 then T=0
    en_cnt = 0; done_cnt = 0;
    start_pulse(12'h903);
    chk("e1_done", DONE, 1'b1);
    chk("e1_err", ERR, 1'b1);
    chk("e1_busy", BUSY, 1'b0);
    cyc();
    chk("e1_done_off", DONE, 1'b0);
    chk("e1_err_hold", ERR, 1'b1);
    cyc();
    start_pulse(12'h760);
    chk("e2_done", DONE, 1'b1);
    chk("e2_err", ERR, 1'b1);
    cyc();
    chk("e2_done_off", DONE, 1'b0);
    chk("e2_err_hold", ERR, 1'b1);
    cyc();
    run_done_checks("err", 0, 2);

    // Single element tile, then the 4 x 1 tile over the same word
    mem[0] = 64'h0001_0002_0003_0004;
    en_cnt = 0; done_cnt = 0;
    push_run(1, 1);
    start_pulse(12'h111);
    chk("t2_err_cleared", ERR, 1'b0);
    wait_done(50);
    chk("t2_first_data", mem[0][63:48], 16'h0001);
    cyc();
    run_done_checks("t2a", 1, 1);
    en_cnt = 0; done_cnt = 0;
    push_run(4, 1);
    start_pulse(12'h411);
    wait_done(50);
    cyc();
    run_done_checks("t2b", 1, 1);

    // Full 8 x 8 tile with a randomly stalling sink
    fill_mem();
    en_cnt = 0; done_cnt = 0;
    push_run(8, 8);
    start_pulse(12'h838);
    rnd = 1;
    wait_done(2000);
    cyc();
    run_done_checks("t3", 16, 1);

    // Reset while word 3 is being emitted, then a fresh readout
    begin
      bit hit = 0;
      en_cnt = 0; done_cnt = 0;
      push_run(8, 4);
      start_pulse(12'h844);
      for (int i = 0; i < 200; i++) begin
        cyc();
        if (O_VALID && ADDR_O == 4'd3) begin
          hit = 1;
          break;
        end
      end
      chk("t5_reach_word3", hit, 1'b1);
    end
    RSTN = 1'b0;
    #1;
    chk_zero();
    exp_q.delete();
    addr_q.delete();
    cyc(); cyc();
    chk_zero();
    RSTN = 1'b1;
    cyc(); cyc();
    chk("t5_stay_idle_busy", BUSY, 1'b0);
    chk("t5_stay_idle_en", EN_O, 1'b0);
    en_cnt = 0; done_cnt = 0;
    push_run(8, 2);
    start_pulse(12'h842);
    chk("t5_restart_en", EN_O, 1'b1);
    chk("t5_restart_addr", ADDR_O, 4'h0);
    wait_done(200);
    cyc();
    run_done_checks("t5", 4, 1);

    // START held: the second readout starts only after the DONE cycle
    en_cnt = 0; done_cnt = 0;
    push_run(2, 2);
    push_run(2, 2);
    MNT = 12'h212;
    START = 1'b1;
    cyc();
    wait_done(100);
    cyc();
    chk("t6_gap_busy", BUSY, 1'b0);
    chk("t6_gap_en", EN_O, 1'b0);
    chk("t6_gap_valid", O_VALID, 1'b0);
    cyc();
    chk("t6_second_en", EN_O, 1'b1);
    START = 1'b0;
    wait_done(100);
    cyc();
    run_done_checks("t6", 4, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
